// File: rtl/gate_sensor_sequencer.sv
// ============================================================================
// Module   : gate_sensor_sequencer
// Purpose  : Debounces entry/exit gate sensors and sequences car passages into
//            single-cycle car_in / car_out / denied / abort event pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sensor_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic clk_2,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    input  logic sensor_exit,
    input  logic lot_full,
    output logic car_in,
    output logic car_out,
    output logic denied,
    output logic abort,
    output logic entry_busy,
    output logic exit_busy
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [2:0] E_IDLE = 3'd0;
    localparam logic [2:0] E_A    = 3'd1;
    localparam logic [2:0] E_AB   = 3'd2;
    localparam logic [2:0] E_B    = 3'd3;
    localparam logic [2:0] E_WAIT = 3'd4;

    localparam logic [1:0] X_IDLE = 2'd0;
    localparam logic [1:0] X_HOLD = 2'd1;
    localparam logic [1:0] X_WAIT = 2'd2;

    logic [2:0] raw;
    logic [2:0] deb;

    assign raw = {sensor_exit, sensor_b, sensor_a};

    // The debounced value flips on the edge that completes DEB_CYCLES disagreeing samples.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            logic          q;
            logic [DW-1:0] cnt;
            always_ff @(posedge clk_2 or posedge reset) begin
                if (reset) begin
                    q   <= 1'b0;
                    cnt <= '0;
                end else if (raw[gi] != q) begin
                    if (cnt == DEB_LAST) begin
                        q   <= raw[gi];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
            assign deb[gi] = q;
        end
    endgenerate

    logic a, b, x;
    assign a = deb[0];
    assign b = deb[1];
    assign x = deb[2];

    logic [2:0]    e_state, e_next;
    logic [TW-1:0] e_tcnt;
    logic          e_active, e_to, car_in_n, denied_n;

    assign e_active = (e_state == E_A) || (e_state == E_AB) || (e_state == E_B);

    always_comb begin
        e_next   = e_state;
        e_to     = 1'b0;
        car_in_n = 1'b0;
        denied_n = 1'b0;
        case (e_state)
            E_IDLE: begin
                if (a && !b) begin
                    e_next   = lot_full ? E_WAIT : E_A;
                    denied_n = lot_full;
                end else if (b) begin
                    e_next = E_WAIT;
                end
            end
            E_A: begin
                if (a && b)        e_next = E_AB;
                else if (!a && !b) e_next = E_IDLE;
            end
            E_AB: begin
                if (!a && b)      e_next = E_B;
                else if (a && !b) e_next = E_A;
            end
            E_B: begin
                if (!a && !b) begin
                    e_next   = E_IDLE;
                    car_in_n = 1'b1;
                end else if (a && b) begin
                    e_next = E_AB;
                end
            end
            E_WAIT: begin
                if (!a && !b) e_next = E_IDLE;
            end
            default: e_next = E_IDLE;
        endcase
        // A real transition always takes precedence over a timeout on the same edge.
        if (e_active && (e_next == e_state) && (e_tcnt == TO_LAST)) begin
            e_next = E_WAIT;
            e_to   = 1'b1;
        end
    end

    logic [1:0]    x_state, x_next;
    logic [TW-1:0] x_tcnt;
    logic          x_active, x_to, car_out_n;

    assign x_active = (x_state == X_HOLD);

    always_comb begin
        x_next    = x_state;
        x_to      = 1'b0;
        car_out_n = 1'b0;
        case (x_state)
            X_IDLE: if (x) x_next = X_HOLD;
            X_HOLD: begin
                if (!x) begin
                    x_next    = X_IDLE;
                    car_out_n = 1'b1;
                end else if (x_tcnt == TO_LAST) begin
                    x_next = X_WAIT;
                    x_to   = 1'b1;
                end
            end
            X_WAIT: if (!x) x_next = X_IDLE;
            default: x_next = X_IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            e_state <= E_IDLE;
            e_tcnt  <= '0;
            x_state <= X_IDLE;
            x_tcnt  <= '0;
            car_in  <= 1'b0;
            car_out <= 1'b0;
            denied  <= 1'b0;
            abort   <= 1'b0;
        end else begin
            e_state <= e_next;
            x_state <= x_next;
            e_tcnt  <= ((e_next != e_state) || !e_active) ? '0 : e_tcnt + 1'b1;
            x_tcnt  <= ((x_next != x_state) || !x_active) ? '0 : x_tcnt + 1'b1;
            car_in  <= car_in_n;
            car_out <= car_out_n;
            denied  <= denied_n;
            abort   <= e_to | x_to;
        end
    end

    assign entry_busy = (e_state != E_IDLE);
    assign exit_busy  = (x_state != X_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gate_sensor_sequencer.sv
// ============================================================================
// Module   : tb_gate_sensor_sequencer
// Purpose  : Scoreboard bench: reference model predicts pulse cycles, monitor
//            compares DUT pulses and busy flags against them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sensor_sequencer;

    localparam int DEB = 4;
    localparam int TO  = 64;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    logic sensor_a = 1'b0, sensor_b = 1'b0, sensor_exit = 1'b0, lot_full = 1'b0;
    logic car_in, car_out, denied, abort, entry_busy, exit_busy;

    gate_sensor_sequencer #(.DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
        .clk_2(clk_2), .reset(reset),
        .sensor_a(sensor_a), .sensor_b(sensor_b), .sensor_exit(sensor_exit),
        .lot_full(lot_full),
        .car_in(car_in), .car_out(car_out), .denied(denied), .abort(abort),
        .entry_busy(entry_busy), .exit_busy(exit_busy)
    );

    always #5 clk_2 = ~clk_2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected pulse cycles per kind: 0 car_in, 1 car_out, 2 denied, 3 abort.
    int    q[4][$];
    int    seen[4];
    int    last[4];
    string names[4] = '{"car_in", "car_out", "denied", "abort"};

    // Reference model: each beam is a debounced level; the entry passage is a
    // named phase with a dwell time, the exit passage likewise.
    typedef enum int {P_IDLE, P_A, P_AB, P_B, P_WAIT} phase_t;
    phase_t ph, ph_before;
    int     etime, xtime;
    int     xph;                 // 0 idle, 1 car present, 2 waiting to clear
    int     da, db, dx, ra, rb, rx;
    bit     ea, eb, ex, hit_abort;
    bit     exp_ebusy, exp_xbusy;

    always @(posedge clk_2) begin
        cyc++;
        if (reset) begin
            ph = P_IDLE; xph = 0; etime = 0; xtime = 0;
            da = 0; db = 0; dx = 0; ra = 0; rb = 0; rx = 0;
        end else begin
            ea = (da != 0); eb = (db != 0); ex = (dx != 0);
            hit_abort = 1'b0;
            ph_before = ph;
            case (ph)
                P_IDLE: if (ea && !eb) begin
                            if (lot_full) begin ph = P_WAIT; q[2].push_back(cyc); end
                            else ph = P_A;
                        end else if (eb) ph = P_WAIT;
                P_A:    if (ea && eb) ph = P_AB; else if (!ea && !eb) ph = P_IDLE;
                P_AB:   if (!ea && eb) ph = P_B; else if (ea && !eb) ph = P_A;
                P_B:    if (!ea && !eb) begin ph = P_IDLE; q[0].push_back(cyc); end
                        else if (ea && eb) ph = P_AB;
                P_WAIT: if (!ea && !eb) ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
            if (ph == ph_before && (ph == P_A || ph == P_AB || ph == P_B)) begin
                etime++;
                if (etime == TO) begin ph = P_WAIT; etime = 0; hit_abort = 1'b1; end
            end else begin
                etime = 0;
            end
            if (xph == 0) begin
                if (ex) xph = 1;
                xtime = 0;
            end else if (xph == 1) begin
                if (!ex) begin xph = 0; xtime = 0; q[1].push_back(cyc); end
                else begin
                    xtime++;
                    if (xtime == TO) begin xph = 2; xtime = 0; hit_abort = 1'b1; end
                end
            end else if (!ex) begin
                xph = 0;
            end
            if (hit_abort) q[3].push_back(cyc);
            if (sensor_a != da) begin ra++; if (ra == DEB) begin da = sensor_a; ra = 0; end end else ra = 0;
            if (sensor_b != db) begin rb++; if (rb == DEB) begin db = sensor_b; rb = 0; end end else rb = 0;
            if (sensor_exit != dx) begin rx++; if (rx == DEB) begin dx = sensor_exit; rx = 0; end end else rx = 0;
        end
        exp_ebusy = (ph != P_IDLE);
        exp_xbusy = (xph != 0);
    end

    // Monitor: pops expected pulse cycles as the DUT presents pulses.
    logic [3:0] obs;
    int         want;
    always @(posedge clk_2) begin
        #1;
        obs = {abort, denied, car_out, car_in};
        for (int k = 0; k < 4; k++) begin
            if (obs[k]) begin
                seen[k]++;
                last[k] = cyc;
                tests++;
                if (q[k].size() == 0) begin
                    fails++;
                    $display("FAIL %s: unexpected pulse at cycle %0d, none expected", names[k], cyc);
                end else begin
                    want = q[k].pop_front();
                    if (want != cyc) begin
                        fails++;
                        $display("FAIL %s: pulse at cycle %0d, expected cycle %0d", names[k], cyc, want);
                    end
                end
            end
            while (q[k].size() > 0 && q[k][0] < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s: missing pulse, expected at cycle %0d", names[k], q[k][0]);
                void'(q[k].pop_front());
            end
        end
        tests++;
        if (entry_busy !== exp_ebusy) begin
            fails++;
            $display("FAIL entry_busy: got %0b, expected %0b at cycle %0d", entry_busy, exp_ebusy, cyc);
        end
        tests++;
        if (exit_busy !== exp_xbusy) begin
            fails++;
            $display("FAIL exit_busy: got %0b, expected %0b at cycle %0d", exit_busy, exp_xbusy, cyc);
        end
    end

    task automatic check_eq(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit a, input bit b, input bit x, input bit lf, input int n);
        sensor_a = a; sensor_b = b; sensor_exit = x; lot_full = lf;
        repeat (n) @(negedge clk_2);
    endtask

    int s[4];
    int mark;

    task automatic snap();
        for (int k = 0; k < 4; k++) s[k] = seen[k];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin seen[k] = 0; last[k] = -1; end
        repeat (3) @(negedge clk_2);
        check_eq("reset_pulses", int'({car_in, car_out, denied, abort}), 0);
        check_eq("reset_busy", int'({entry_busy, exit_busy}), 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 5);

        // Normal A -> AB -> B -> clear passage
        snap();
        drive(1, 0, 0, 0, 10);
        drive(1, 1, 0, 0, 10);
        drive(0, 1, 0, 0, 10);
        mark = cyc;
        drive(0, 0, 0, 0, 10);
        check_eq("pass_car_in_count", seen[0] - s[0], 1);
        check_eq("pass_car_in_latency", last[0] - mark, DEB + 1);
        check_eq("pass_entry_busy", int'(entry_busy), 0);

        // Short glitch on A is filtered
        snap();
        drive(1, 0, 0, 0, 3);
        check_eq("glitch_busy", int'(entry_busy), 0);
        drive(0, 0, 0, 0, 10);
        check_eq("glitch_pulses", (seen[0]-s[0]) + (seen[2]-s[2]) + (seen[3]-s[3]), 0);

        // Car backs out
        snap();
        drive(1, 0, 0, 0, 10);
        drive(1, 1, 0, 0, 10);
        drive(1, 0, 0, 0, 10);
        drive(0, 0, 0, 0, 10);
        check_eq("backout_car_in", seen[0] - s[0], 0);
        check_eq("backout_busy", int'(entry_busy), 0);

        // Entry attempt with full lot
        snap();
        drive(1, 0, 0, 1, 10);
        check_eq("full_denied", seen[2] - s[2], 1);
        check_eq("full_wait_busy", int'(entry_busy), 1);
        drive(0, 0, 0, 1, 10);
        check_eq("full_idle_busy", int'(entry_busy), 0);
        check_eq("full_car_in", seen[0] - s[0], 0);

        // Entry timeout
        snap();
        mark = cyc;
        drive(1, 0, 0, 0, 80);
        check_eq("to_abort_count", seen[3] - s[3], 1);
        check_eq("to_abort_cycle", last[3] - mark, DEB + 1 + TO);
        check_eq("to_still_busy", int'(entry_busy), 1);
        drive(0, 0, 0, 0, 10);
        check_eq("to_idle_busy", int'(entry_busy), 0);

        // Entry and exit completing together
        snap();
        drive(1, 0, 0, 0, 10);
        drive(1, 1, 0, 0, 10);
        drive(0, 1, 1, 0, 10);
        drive(0, 0, 0, 0, 10);
        check_eq("conc_car_in", seen[0] - s[0], 1);
        check_eq("conc_car_out", seen[1] - s[1], 1);
        check_eq("conc_same_cycle", last[0] - last[1], 0);

        // Reset during an exit passage
        snap();
        drive(0, 0, 1, 0, 10);
        drive(0, 0, 0, 0, 2);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_outputs", int'({car_in, car_out, denied, abort, entry_busy, exit_busy}), 0);
        repeat (2) @(negedge clk_2);
        reset = 1'b0;
        drive(0, 0, 0, 0, 10);
        check_eq("rst_mid_car_out", seen[1] - s[1], 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(1, 12));
        end
        drive(0, 0, 0, 0, 20);
        for (int k = 0; k < 4; k++) check_eq({"drain_", names[k]}, q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
